// File: rtl/clk_div_pkg.sv
// Purpose : shared phase encoding and ratio-to-phase-length helper for the clock dividers.
// Latency : n/a (types, constants and a pure function only).
// Backpres: n/a.
//
// A ratio N splits into a low phase floor(N/2) and a high phase N-floor(N/2), so an odd
// ratio gives its extra reference cycle to the high phase. Supports WIDTH up to 32.
package clk_div_pkg;

    localparam logic LOW_PHASE  = 1'b0;
    localparam logic HIGH_PHASE = 1'b1;

    typedef struct packed {
        logic [31:0] low_len;
        logic [31:0] high_len;
    } phase_len_t;

    function automatic phase_len_t phase_lengths(input logic [31:0] ratio);
        phase_len_t lens;
        lens.low_len  = ratio >> 1;
        lens.high_len = ratio - (ratio >> 1);
        return lens;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// Purpose : one programmable divider channel with a boundary-aligned ratio update.
// Latency : first divided rising edge L ref cycles after enable is sampled; ratio update lands on the next period boundary.
// Backpres: none; a newer ratio load overwrites an unapplied one (last write wins).
//
// Ports: i_ref_clk/i_rst     reference clock, synchronous active-high reset
//        i_clk_en            divide enable
//        i_div_ratio         ratio N, captured into the pending register by i_ratio_load
//        o_div_clk           registered divided clock, or i_ref_clk in bypass
//        o_rise_pulse        first ref cycle of each divided high phase
//        o_ratio_busy        pending ratio not yet applied
module clk_div_chan #(
    parameter int WIDTH = 8
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [WIDTH-1:0] i_div_ratio,
    input  logic             i_ratio_load,
    output logic             o_div_clk,
    output logic             o_rise_pulse,
    output logic             o_ratio_busy
);
    import clk_div_pkg::*;

    logic [WIDTH-1:0] act_ratio_q;
    logic [WIDTH-1:0] pend_ratio_q;
    logic             pend_q;
    logic [WIDTH-2:0] cnt_q;
    logic             div_q;
    logic             div_prev_q;
    logic             phase_q;
    // run_q is the registered "dividing" state; it drives the output mux so that
    // leaving or entering bypass always happens on a ref clock edge.
    logic             run_q;

    phase_len_t       lens;
    logic [31:0]      term_cnt;
    logic             go;
    logic             term;
    logic             boundary;
    logic             apply;

    assign lens     = phase_lengths(32'(act_ratio_q));
    assign go       = i_clk_en && (act_ratio_q >= WIDTH'(2));
    assign term_cnt = (phase_q == HIGH_PHASE) ? lens.high_len - 32'd1
                                              : lens.low_len  - 32'd1;
    assign term     = run_q && go && (32'(cnt_q) == term_cnt);
    // The high-to-low toggle closes a period; that is the only place a running
    // channel may change ratio, which is what keeps runt pulses off o_div_clk.
    assign boundary = term && (phase_q == HIGH_PHASE);
    assign apply    = pend_q && (boundary || !run_q);

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            act_ratio_q  <= '0;
            pend_ratio_q <= '0;
            pend_q       <= 1'b0;
            cnt_q        <= '0;
            div_q        <= 1'b0;
            div_prev_q   <= 1'b0;
            phase_q      <= LOW_PHASE;
            run_q        <= 1'b0;
        end else begin
            div_prev_q <= div_q;

            // A load on the applying edge stays pending for the following boundary.
            if (i_ratio_load) begin
                pend_ratio_q <= i_div_ratio;
                pend_q       <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end

            if (apply) begin
                act_ratio_q <= pend_ratio_q;
            end

            if (!go) begin
                run_q   <= 1'b0;
                cnt_q   <= '0;
                div_q   <= 1'b0;
                phase_q <= LOW_PHASE;
            end else if (!run_q) begin
                // Fresh low phase. With an update pending, apply it first and start on
                // the next edge so a ratio below 2 never produces a dividing cycle.
                run_q   <= !pend_q;
                cnt_q   <= '0;
                div_q   <= 1'b0;
                phase_q <= LOW_PHASE;
            end else if (term) begin
                cnt_q   <= '0;
                div_q   <= ~div_q;
                phase_q <= ~phase_q;
                // New ratio below 2: the period just completed, drop straight to bypass.
                if (apply && (pend_ratio_q < WIDTH'(2))) begin
                    run_q <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_div_clk    = run_q ? div_q : i_ref_clk;
    assign o_rise_pulse = div_q & ~div_prev_q;
    assign o_ratio_busy = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Purpose : CHANNELS independent programmable clock dividers off one reference clock.
// Latency : per channel, first divided rise L ref cycles after enable; ratio updates at period boundaries.
// Backpres: none; o_ratio_busy reports an unapplied ratio, later loads overwrite it.
//
// Ports: i_ref_clk, i_rst (sync, active-high); per channel k: i_clk_en[k], i_ratio_load[k],
//        i_div_ratio[k*WIDTH +: WIDTH], o_div_clk[k], o_rise_pulse[k], o_ratio_busy[k].
module clk_div_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      i_ref_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS-1:0]       i_clk_en,
    input  logic [CHANNELS*WIDTH-1:0] i_div_ratio,
    input  logic [CHANNELS-1:0]       i_ratio_load,
    output logic [CHANNELS-1:0]       o_div_clk,
    output logic [CHANNELS-1:0]       o_rise_pulse,
    output logic [CHANNELS-1:0]       o_ratio_busy
);
    import clk_div_pkg::*;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        clk_div_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .i_ref_clk    (i_ref_clk),
            .i_rst        (i_rst),
            .i_clk_en     (i_clk_en[k]),
            .i_div_ratio  (i_div_ratio[k*WIDTH +: WIDTH]),
            .i_ratio_load (i_ratio_load[k]),
            .o_div_clk    (o_div_clk[k]),
            .o_rise_pulse (o_rise_pulse[k]),
            .o_ratio_busy (o_ratio_busy[k])
        );
    end

endmodule
